// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch slice
package fetch_pkg;
    typedef logic [31:0] pc_t;
    typedef logic [31:0] instr_t;
    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;
    localparam pc_t PC_STEP = 32'd4;
    typedef enum logic [1:0] {RUN, STALL, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry circular FIFO of fetch entries with flush and registered head
module fetch_buf
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_push = push_i & ~flush_i;
        do_pop  = pop_i & ~flush_i & (cnt_q != '0);
        wr_d    = flush_i ? '0 : do_push ? nxt(wr_q) : wr_q;
        rd_d    = flush_i ? '0 : do_pop ? nxt(rd_q) : rd_q;
        cnt_d   = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= push_data_i;
        end
    end

    // the issue credit rule upstream must make this unreachable
    assert property (@(posedge clk) disable iff (!rst_n) !(do_push && cnt_q == CW'(DEPTH)));

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, credit-based issue and redirect flushing in front of decode
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter pc_t RESET_PC = 32'h0000_0000,
    parameter int  DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int CW = $clog2(DEPTH + 1);

    pc_t           pc_q, pc_d, infl_pc_q, infl_pc_d;
    logic          infl_q, infl_d, pop;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    fetch_state_t  state;
    fetch_entry_t  head;

    // a slot is free once the buffer, the word in flight and this cycle's pop leave room
    always_comb begin
        pop       = out_valid & out_ready;
        used      = {1'b0, count} + (CW+1)'(infl_q) - (CW+1)'(pop);
        state     = redirect_valid ? FLUSH : (used < (CW+1)'(DEPTH)) ? RUN : STALL;
        pc_d      = state == FLUSH ? {redirect_pc[31:2], 2'b00} : state == RUN ? pc_q + PC_STEP : pc_q;
        infl_d    = state == RUN;
        infl_pc_d = state == RUN ? pc_q : infl_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (infl_q & ~redirect_valid),
        .push_data_i ({infl_pc_q, mem_rdata}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (count),
        .head_o      (head)
    );

    assign mem_addr  = pc_q;
    assign out_valid = count != '0;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
endmodule
